// File: rtl/ripple_adder_reg.sv
// Registered ripple-carry adder: a + b + cin through a chain of one-bit full-adder
// cells, with sum, carry-out and signed overflow captured alongside a valid flag.

module ripple_adder_fa (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

module ripple_adder_reg #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf,
  output logic             out_valid
);

  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] s_comb;
  logic             cout_comb;
  logic             ovf_comb;

  logic [WIDTH-1:0] s_reg;
  logic             cout_reg;
  logic             ovf_reg;
  logic             out_valid_reg;

  assign c[0] = cin;

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
      ripple_adder_fa u_fa (
        .a  (a[gi]),
        .b  (b[gi]),
        .ci (c[gi]),
        .s  (s_comb[gi]),
        .co (c[gi+1])
      );
    end
  endgenerate

  // With WIDTH=1, c[WIDTH-1] is cin itself, so one expression covers every width.
  assign cout_comb = c[WIDTH];
  assign ovf_comb  = c[WIDTH] ^ c[WIDTH-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_reg         <= '0;
      cout_reg      <= 1'b0;
      ovf_reg       <= 1'b0;
      out_valid_reg <= 1'b0;
    end else begin
      out_valid_reg <= in_valid;
      if (in_valid) begin
        s_reg    <= s_comb;
        cout_reg <= cout_comb;
        ovf_reg  <= ovf_comb;
      end
    end
  end

  assign s         = s_reg;
  assign cout      = cout_reg;
  assign ovf       = ovf_reg;
  assign out_valid = out_valid_reg;

endmodule

// File: tb/tb_ripple_adder_reg.sv
// Directed and swept checks of ripple_adder_reg at WIDTH 4 (main), 1, 8 and 16.

module tb_ripple_adder_reg;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  logic        iv4 = 0, cin4 = 0, s_cout4, ovf4, ov4;
  logic [3:0]  a4 = 0, b4 = 0, s4;
  logic        iv1 = 0, cin1 = 0, cout1, ovf1, ov1;
  logic [0:0]  a1 = 0, b1 = 0, s1;
  logic        iv8 = 0, cin8 = 0, cout8, ovf8, ov8;
  logic [7:0]  a8 = 0, b8 = 0, s8;
  logic        iv16 = 0, cin16 = 0, cout16, ovf16, ov16;
  logic [15:0] a16 = 0, b16 = 0, s16;

  ripple_adder_reg #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv4), .a(a4), .b(b4), .cin(cin4),
    .s(s4), .cout(s_cout4), .ovf(ovf4), .out_valid(ov4));
  ripple_adder_reg #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv1), .a(a1), .b(b1), .cin(cin1),
    .s(s1), .cout(cout1), .ovf(ovf1), .out_valid(ov1));
  ripple_adder_reg #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .a(a8), .b(b8), .cin(cin8),
    .s(s8), .cout(cout8), .ovf(ovf8), .out_valid(ov8));
  ripple_adder_reg #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv16), .a(a16), .b(b16), .cin(cin16),
    .s(s16), .cout(cout16), .ovf(ovf16), .out_valid(ov16));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Exact unsigned result {cout, s} in w+1 bits.
  function automatic longint unsigned model_sum(int w, longint unsigned x, longint unsigned y, bit ci);
    longint unsigned mask;
    mask = (64'd1 << (w + 1)) - 1;
    return (x + y + 64'(ci)) & mask;
  endfunction

  // Signed overflow: true signed sum falls outside the w-bit two's complement range.
  function automatic bit model_ovf(int w, longint unsigned x, longint unsigned y, bit ci);
    longint sx, sy, sum, lo, hi;
    sx = longint'(x);
    sy = longint'(y);
    if (((x >> (w - 1)) & 1) == 1) sx = sx - (longint'(1) << w);
    if (((y >> (w - 1)) & 1) == 1) sy = sy - (longint'(1) << w);
    sum = sx + sy + longint'(ci);
    hi  = (longint'(1) << (w - 1)) - 1;
    lo  = -(longint'(1) << (w - 1));
    return (sum > hi) || (sum < lo);
  endfunction

  task automatic zeros_all(input string tag);
    check({tag, " s4"}, 64'(s4), 64'd0);
    check({tag, " cout4"}, 64'(s_cout4), 64'd0);
    check({tag, " ovf4"}, 64'(ovf4), 64'd0);
    check({tag, " ov4"}, 64'(ov4), 64'd0);
    check({tag, " w1"}, 64'({s1, cout1, ovf1, ov1}), 64'd0);
    check({tag, " w8"}, 64'({s8, cout8, ovf8, ov8}), 64'd0);
    check({tag, " w16"}, 64'({s16, cout16, ovf16, ov16}), 64'd0);
  endtask

  // Present one operand set to the WIDTH=4 instance and check the registered result.
  task automatic apply4(input logic [3:0] x, input logic [3:0] y, input logic ci,
                        input logic [3:0] es, input logic ec, input logic eo);
    @(negedge clk);
    iv4 = 1'b1; a4 = x; b4 = y; cin4 = ci;
    @(posedge clk);
    #1;
    $display("w4 %0d+%0d+%0d -> s=%0d cout=%0d ovf=%0d valid=%0d", x, y, ci, s4, s_cout4, ovf4, ov4);
    check("w4 s", 64'(s4), 64'(es));
    check("w4 cout", 64'(s_cout4), 64'(ec));
    check("w4 ovf", 64'(ovf4), 64'(eo));
    check("w4 valid", 64'(ov4), 64'd1);
  endtask

  typedef struct {
    logic [3:0] a, b;
    logic       ci;
    logic [3:0] s;
    logic       co, ov;
  } vec_t;

  vec_t dir_vecs[8] = '{
    '{4'd0,  4'd0,  1'b0, 4'd0,  1'b0, 1'b0},
    '{4'd15, 4'd1,  1'b0, 4'd0,  1'b1, 1'b0},
    '{4'd15, 4'd15, 1'b1, 4'd15, 1'b1, 1'b0},
    '{4'd9,  4'd6,  1'b1, 4'd0,  1'b1, 1'b0},
    '{4'd7,  4'd1,  1'b0, 4'd8,  1'b0, 1'b1},
    '{4'd8,  4'd8,  1'b0, 4'd0,  1'b1, 1'b1},
    '{4'd5,  4'd2,  1'b0, 4'd7,  1'b0, 1'b0},
    '{4'd7,  4'd0,  1'b1, 4'd8,  1'b0, 1'b1}
  };

  initial begin
    longint unsigned e;
    logic [3:0] x, y;
    logic ci;

    // Reset from time zero, released away from a clock edge.
    #1 rst_n = 1'b0;
    #2 zeros_all("reset");
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    zeros_all("post-release");

    // Hand-computed directed vectors, back to back.
    foreach (dir_vecs[i])
      apply4(dir_vecs[i].a, dir_vecs[i].b, dir_vecs[i].ci,
             dir_vecs[i].s, dir_vecs[i].co, dir_vecs[i].ov);

    // Exhaustive WIDTH=4 sweep, in_valid high every cycle.
    for (int i = 0; i < 512; i++) begin
      x  = 4'(i >> 5);
      y  = 4'(i >> 1);
      ci = i[0];
      e  = model_sum(4, 64'(x), 64'(y), ci);
      apply4(x, y, ci, e[3:0], e[4], model_ovf(4, 64'(x), 64'(y), ci));
    end

    // Hold: inputs wiggle with in_valid low; result stays put.
    apply4(4'd3, 4'd4, 1'b0, 4'd7, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      iv4 = 1'b0; a4 = 4'($urandom); b4 = 4'($urandom); cin4 = 1'($urandom);
      @(posedge clk); #1;
      $display("w4 hold cycle %0d -> s=%0d valid=%0d", i, s4, ov4);
      check("hold s", 64'(s4), 64'd7);
      check("hold cout", 64'(s_cout4), 64'd0);
      check("hold valid", 64'(ov4), 64'd0);
    end

    // Asynchronous reset between edges clears everything immediately.
    apply4(4'd15, 4'd15, 1'b1, 4'd15, 1'b1, 1'b0);
    #3 rst_n = 1'b0;
    #1 zeros_all("async reset");
    @(negedge clk) rst_n = 1'b1;
    iv4 = 1'b0;

    // Reset mid-stream: the in-flight 12+3+1 result is discarded.
    @(negedge clk);
    iv4 = 1'b1; a4 = 4'd12; b4 = 4'd3; cin4 = 1'b1;
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1 zeros_all("midstream reset");
    @(posedge clk); #1;
    check("midstream held valid", 64'(ov4), 64'd0);
    @(negedge clk) iv4 = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    $display("w4 after midstream reset -> s=%0d valid=%0d", s4, ov4);
    check("midstream s", 64'(s4), 64'd0);
    check("midstream valid", 64'(ov4), 64'd0);
    apply4(4'd12, 4'd3, 1'b1, 4'd0, 1'b1, 1'b0);
    @(negedge clk) iv4 = 1'b0;

    // WIDTH=1 corner: 1+1+1.
    @(negedge clk);
    iv1 = 1'b1; a1 = 1'b1; b1 = 1'b1; cin1 = 1'b1;
    @(posedge clk); #1;
    $display("w1 1+1+1 -> s=%0d cout=%0d ovf=%0d", s1, cout1, ovf1);
    check("w1 111 s", 64'(s1), 64'd1);
    check("w1 111 cout", 64'(cout1), 64'd1);
    check("w1 111 ovf", 64'(ovf1), 64'd0);
    check("w1 111 valid", 64'(ov1), 64'd1);

    // Random sweep at widths 1, 8, 16 simultaneously.
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      iv1 = 1'b1; iv8 = 1'b1; iv16 = 1'b1;
      a1 = 1'($urandom);   b1 = 1'($urandom);   cin1 = 1'($urandom);
      a8 = 8'($urandom);   b8 = 8'($urandom);   cin8 = 1'($urandom);
      a16 = 16'($urandom); b16 = 16'($urandom); cin16 = 1'($urandom);
      if (i == 0) begin
        a8 = 8'h7f; b8 = 8'h01; cin8 = 1'b0;
        a16 = 16'hffff; b16 = 16'hffff; cin16 = 1'b1;
      end
      @(posedge clk); #1;
      $display("sweep %0d: w1 %0h+%0h+%0h=%0h w8 %0h+%0h+%0h=%0h w16 %0h+%0h+%0h=%0h",
               i, a1, b1, cin1, {cout1, s1}, a8, b8, cin8, {cout8, s8},
               a16, b16, cin16, {cout16, s16});
      check("w1 sum", 64'({cout1, s1}), model_sum(1, 64'(a1), 64'(b1), cin1));
      check("w1 ovf", 64'(ovf1), 64'(model_ovf(1, 64'(a1), 64'(b1), cin1)));
      check("w8 sum", 64'({cout8, s8}), model_sum(8, 64'(a8), 64'(b8), cin8));
      check("w8 ovf", 64'(ovf8), 64'(model_ovf(8, 64'(a8), 64'(b8), cin8)));
      check("w16 sum", 64'({cout16, s16}), model_sum(16, 64'(a16), 64'(b16), cin16));
      check("w16 ovf", 64'(ovf16), 64'(model_ovf(16, 64'(a16), 64'(b16), cin16)));
      check("sweep valid", 64'({ov1, ov8, ov16}), 64'd7);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
